// File: rtl/mips_cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_bus_pkg
//  Description : Shared types and constants for the bus memory access unit:
//                access-size encoding, FSM state encoding, lane enables.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_cpu_bus_pkg;

    // Access size as presented on req_size; 2'b11 is reserved (error)
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    // Transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RDATA = 2'd2
    } state_e;

    // Byteenable patterns; offset k drives byteenable[k]
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_H0   = 4'b0011;
    localparam logic [3:0] BE_H2   = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage : mips_cpu_bus_pkg
`default_nettype wire

// File: rtl/mips_cpu_bus_lane.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_bus_lane
//  Description : Combinational lane logic. Request side: alignment check,
//                byteenable and store-data steering. Load side: lane
//                extraction and sign/zero extension. Offset k maps to data
//                bits [31-8k -: 8].
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_bus_lane
    import mips_cpu_bus_pkg::*;
(
    input  logic [1:0]  i_req_size,
    input  logic [1:0]  i_req_off,
    input  logic [31:0] i_req_wdata,
    output logic [3:0]  o_req_be,
    output logic [31:0] o_req_wdata,
    output logic        o_req_misaligned,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_signed,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Request decode: enables, steered store data and alignment error
    always_comb begin
        o_req_be         = BE_NONE;
        o_req_wdata      = 32'h0;
        o_req_misaligned = 1'b0;
        case (i_req_size)
            SIZE_BYTE: begin
                o_req_be    = BE_B0 << i_req_off;
                o_req_wdata = {i_req_wdata[7:0], 24'h0} >> {i_req_off, 3'b000};
            end
            SIZE_HALF: begin
                if (i_req_off[0]) begin
                    o_req_misaligned = 1'b1;
                end else if (i_req_off[1]) begin
                    o_req_be    = BE_H2;
                    o_req_wdata = {16'h0, i_req_wdata[15:0]};
                end else begin
                    o_req_be    = BE_H0;
                    o_req_wdata = {i_req_wdata[15:0], 16'h0};
                end
            end
            SIZE_WORD: begin
                if (i_req_off != 2'b00) begin
                    o_req_misaligned = 1'b1;
                end else begin
                    o_req_be    = BE_WORD;
                    o_req_wdata = i_req_wdata;
                end
            end
            default: o_req_misaligned = 1'b1;
        endcase
    end

    // Load extraction: only the selected lane reaches the result, so
    // undriven (X) lanes on the bus never leak into the response
    always_comb begin
        w_ld_byte = 8'h0;
        case (i_ld_off)
            2'd0:    w_ld_byte = i_ld_rdata[31:24];
            2'd1:    w_ld_byte = i_ld_rdata[23:16];
            2'd2:    w_ld_byte = i_ld_rdata[15:8];
            default: w_ld_byte = i_ld_rdata[7:0];
        endcase
        w_ld_half = i_ld_off[1] ? i_ld_rdata[15:0] : i_ld_rdata[31:16];
        case (i_ld_size)
            SIZE_BYTE: o_ld_data = {{24{i_ld_signed & w_ld_byte[7]}}, w_ld_byte};
            SIZE_HALF: o_ld_data = {{16{i_ld_signed & w_ld_half[15]}}, w_ld_half};
            default:   o_ld_data = i_ld_rdata;
        endcase
    end

endmodule : mips_cpu_bus_lane
`default_nettype wire

// File: rtl/mips_cpu_bus_mau.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_bus_mau
//  Description : Avalon-MM master memory access unit. Turns one core
//                load/store request into one Avalon read or write, handling
//                waitrequest stalls and load extension.
//                Optional macro MIPS_BUS_TIMEOUT_EN adds a waitrequest
//                timeout (TIMEOUT_CYCLES) that aborts with rsp_err.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_bus_mau
    import mips_cpu_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

`ifdef MIPS_BUS_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 64;
    localparam int unsigned c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [c_CNT_W-1:0] r_cnt;
`endif

    state_e      r_state;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_address;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_ld_size;
    logic [1:0]  r_ld_off;
    logic        r_ld_signed;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misaligned;
    logic [31:0] w_ld_data;

    mips_cpu_bus_lane u_lane (
        .i_req_size       (req_size),
        .i_req_off        (req_addr[1:0]),
        .i_req_wdata      (req_wdata),
        .o_req_be         (w_be),
        .o_req_wdata      (w_wdata),
        .o_req_misaligned (w_misaligned),
        .i_ld_size        (r_ld_size),
        .i_ld_off         (r_ld_off),
        .i_ld_signed      (r_ld_signed),
        .i_ld_rdata       (readdata),
        .o_ld_data        (w_ld_data)
    );

    // Transaction FSM; response fields default to zero so rsp_valid pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= 32'h0;
            r_be        <= BE_NONE;
            r_wdata     <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_ld_size   <= 2'b00;
            r_ld_off    <= 2'b00;
            r_ld_signed <= 1'b0;
`ifdef MIPS_BUS_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (w_misaligned) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_address   <= {req_addr[31:2], 2'b00};
                            r_be        <= w_be;
                            r_wdata     <= w_wdata;
                            r_read      <= ~req_write;
                            r_write     <= req_write;
                            r_ld_size   <= req_size;
                            r_ld_off    <= req_addr[1:0];
                            r_ld_signed <= req_signed;
                            r_state     <= ST_BUS;
`ifdef MIPS_BUS_TIMEOUT_EN
                            r_cnt       <= '0;
`endif
                        end
                    end
                end
                ST_BUS: begin
                    if (!waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_write) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state <= ST_RDATA;
                        end
                    end
`ifdef MIPS_BUS_TIMEOUT_EN
                    else if (r_cnt == c_TMO_LAST) begin
                        r_read      <= 1'b0;
                        r_write     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_RDATA: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_ld_data;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign writedata  = r_wdata;
    assign byteenable = r_be;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_rdata  = r_rsp_rdata;

endmodule : mips_cpu_bus_mau
`default_nettype wire

// File: doc/mips_cpu_bus_mau.md
Name: mips_cpu_bus_mau

Overview:
Avalon-MM master-side memory access unit for the bus CPU. It converts one load/store request from the CPU core into a single Avalon read or write transaction. Each request is a byte, half or word access. The unit handles byte-lane steering, byteenable generation, waitrequest stalls and load sign/zero extension. It sits between the core datapath and the external bus; instruction fetch and data accesses share it.

Parameters:
TIMEOUT_CYCLES, 64, max consecutive waitrequest-stalled cycles before abort (only with the optional feature)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (asserted when 0)
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request (high only in IDLE)
req_write  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as error)
req_signed  in  1  sign-extend load result (byte/half only)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle response pulse
rsp_err  out  1  misaligned/reserved/timeout, valid with rsp_valid
rsp_rdata  out  32  extended load data, valid with rsp_valid (0 for stores/errors)
busy  out  1  high in any state other than IDLE
address  out  32  Avalon byte address, bits[1:0] always 0
read  out  1  Avalon read
write  out  1  Avalon write
waitrequest  in  1  Avalon slave stall
writedata  out  32  Avalon write data
byteenable  out  4  Avalon lane enables
readdata  in  32  Avalon read data

Behaviour:
- Reset (reset==0 at posedge): state=IDLE.
  - read=write=0, byteenable=0, address=0, writedata=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0.
  - Reset mid-transaction abandons it; no response is issued.
- Lane convention: byte offset k=addr[1:0] maps to byteenable[k] and data bits [31-8k -: 8].
  - Byte: be = one-hot bit k.
  - Half at offset 0: be=0011, data[31:16].
  - Half at offset 2: be=1100, data[15:0].
  - Word: be=1111.
  - Store data is replicated/steered into its lane; other lanes are don't-care but driven 0.
- Alignment error: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - No bus transaction.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - State stays IDLE.
- FSM states and transitions:
  - IDLE: req_ready=1.
    - req_valid & aligned: latch address/be/writedata, go to BUS.
  - BUS: read or write=1 (never both); address/byteenable/writedata held stable.
    - Stay in BUS while waitrequest=1.
    - Posedge with waitrequest=0 accepts the transaction.
    - Store: go to IDLE, rsp_valid=1 next cycle.
    - Load: go to RDATA; read/write drop to 0 at this same edge.
  - RDATA: readdata is valid this cycle (fixed 1-cycle read latency).
    - Extract lane(s), extend per req_signed, register into rsp_rdata.
    - Go to IDLE with rsp_valid=1.
- Latency with no stalls, counting from the request-accept edge:
  - Store: rsp_valid in cycle +2.
  - Load: rsp_valid in cycle +3.
  - Each waitrequest cycle adds 1.
- rsp_valid is a single-cycle pulse with no backpressure; the core must sample it.
- A new request may be accepted in the same cycle rsp_valid is high (IDLE).
- waitrequest is ignored outside BUS. readdata is sampled only in RDATA; disabled lanes may be X and must not propagate.

Optional Feature:
MIPS_BUS_TIMEOUT_EN
- Defined:
  - A counter in BUS increments on each waitrequest=1 cycle and clears on entry to BUS.
  - On reaching TIMEOUT_CYCLES: deassert read/write, go to IDLE, pulse rsp_valid with rsp_err=1.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Package mips_cpu_bus_pkg holds:
  - size enum (SIZE_BYTE/HALF/WORD);
  - FSM state enum (IDLE/BUS/RDATA);
  - BE_* byteenable constants.
- Sub-module mips_cpu_bus_lane: combinational store-lane steering, byteenable generation, load extraction/extension and misalignment detect.

Test Plan:
- Word store, addr=0xBFC00010, wdata=0xDEADBEEF, waitrequest=0 -> one write cycle with address=0xBFC00010, be=1111, writedata=0xDEADBEEF; rsp_valid at +2, rsp_err=0.
- Byte load, signed, addr=0xBFC00013, memory word 0x1122338F, 3 waitrequest cycles -> read held 4 cycles, be=1000; rsp_rdata=0xFFFFFF8F at +6.
- Half load, unsigned, addr=0xBFC00012, word 0x1234ABCD -> be=1100, rsp_rdata=0x0000ABCD.
- Half store, addr=0xBFC00021 -> no read/write asserted; next cycle rsp_valid=1, rsp_err=1.
- Reset driven to 0 while in BUS with waitrequest=1 -> at that edge read=0, busy=0, no rsp_valid; a following request completes normally.
- With MIPS_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck 1 -> read drops after 8 stall cycles, rsp_valid=1, rsp_err=1.
